// File: rtl/bcd_udcnt_n_pkg.sv
// Shared constants and helpers for the multi-digit up/down counter.
package bcd_udcnt_n_pkg;

  localparam int DIGIT_W    = 4;
  localparam int DIGITS_MAX = 8;

  // Terminal value of one digit for the current count direction.
  function automatic logic [DIGIT_W-1:0] digit_limit(input logic up, input int modulus);
    return up ? DIGIT_W'(modulus - 1) : '0;
  endfunction

endpackage

// File: rtl/bcd_udcnt_n_if.sv
// Control/data bundle of the counter: master drives controls, slave is the counter.
interface bcd_udcnt_n_if #(parameter int DIGITS = 4);
  import bcd_udcnt_n_pkg::*;

  logic                      CLR;
  logic                      LOAD;
  logic [DIGIT_W*DIGITS-1:0] D;
  logic                      EN;
  logic                      CI;
  logic                      UP;
  logic [DIGIT_W*DIGITS-1:0] Q;
  logic                      TC;
  logic                      CO;
  logic                      WRAP;
  logic                      LDERR;

  modport master (output CLR, LOAD, D, EN, CI, UP,
                  input  Q, TC, CO, WRAP, LDERR);
  modport slave  (input  CLR, LOAD, D, EN, CI, UP,
                  output Q, TC, CO, WRAP, LDERR);
endinterface

// File: rtl/bcd_udcnt_digit.sv
// One modulo-MODULUS digit cell: clear, clamped load, up/down step, limit flag.
module bcd_udcnt_digit
  import bcd_udcnt_n_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic               CLK,
  input  logic               RESET_B,
  input  logic               CLR,
  input  logic               LOAD,
  input  logic [DIGIT_W-1:0] D,
  input  logic               EN_IN,
  input  logic               UP,
  input  logic               HOLD,
  output logic [DIGIT_W-1:0] Q,
  output logic               AT_LIMIT
);

  localparam logic [DIGIT_W:0]   MOD_X = (DIGIT_W+1)'(MODULUS);
  localparam logic [DIGIT_W-1:0] TOP   = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] q_q, q_d;

  // Next digit value: clear beats load beats step; HOLD freezes a saturated count.
  always_comb begin
    q_d = q_q;
    if (CLR) begin
      q_d = '0;
    end else if (LOAD) begin
      q_d = ({1'b0, D} >= MOD_X) ? TOP : D;
    end else if (EN_IN && !HOLD) begin
      if (UP) q_d = (q_q == TOP) ? '0 : q_q + 1'b1;
      else    q_d = (q_q == '0) ? TOP : q_q - 1'b1;
    end
  end

  // Digit state register.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) q_q <= '0;
    else          q_q <= q_d;
  end

  assign Q        = q_q;
  assign AT_LIMIT = (q_q == digit_limit(UP, MODULUS));

endmodule

// File: rtl/bcd_udcnt_n.sv
// Cascadable DIGITS x modulo-MODULUS up/down counter with wrap or saturate mode.
module bcd_udcnt_n
  import bcd_udcnt_n_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int MODULUS = 10,
  parameter bit SAT     = 1'b0
) (
  input  logic         CLK,
  input  logic         RESET_B,
  bcd_udcnt_n_if.slave bus
);

  localparam logic [DIGIT_W:0] MOD_X = (DIGIT_W+1)'(MODULUS);

  if (DIGITS < 1 || DIGITS > DIGITS_MAX) begin : g_bad_digits
    $error("bcd_udcnt_n: DIGITS out of range");
  end

  logic [DIGITS-1:0] en_in;
  logic [DIGITS-1:0] at_limit;
  logic              eff_en, tc, hold, any_oor;
  logic              wrap_q, wrap_d, lderr_q, lderr_d;

  assign eff_en = bus.EN & bus.CI;
  assign tc     = &at_limit;
  assign hold   = SAT & tc;

  // Ripple enable: a digit steps only when every lower digit sits at its limit.
  always_comb begin
    en_in[0] = eff_en;
    for (int k = 1; k < DIGITS; k++) en_in[k] = en_in[k-1] & at_limit[k-1];
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    bcd_udcnt_digit #(.MODULUS(MODULUS)) u_dig (
      .CLK      (CLK),
      .RESET_B  (RESET_B),
      .CLR      (bus.CLR),
      .LOAD     (bus.LOAD),
      .D        (bus.D[DIGIT_W*k +: DIGIT_W]),
      .EN_IN    (en_in[k]),
      .UP       (bus.UP),
      .HOLD     (hold),
      .Q        (bus.Q[DIGIT_W*k +: DIGIT_W]),
      .AT_LIMIT (at_limit[k])
    );
  end

  // Any load field that will be clamped.
  always_comb begin
    any_oor = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      any_oor = any_oor | ({1'b0, bus.D[DIGIT_W*k +: DIGIT_W]} >= MOD_X);
  end

  // Event pulses: a counted step at terminal count, or a clamped load.
  always_comb begin
    wrap_d  = !bus.CLR && !bus.LOAD && eff_en && tc;
    lderr_d = !bus.CLR && bus.LOAD && any_oor;
  end

  // Pulse registers.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      wrap_q  <= 1'b0;
      lderr_q <= 1'b0;
    end else begin
      wrap_q  <= wrap_d;
      lderr_q <= lderr_d;
    end
  end

  assign bus.TC    = tc;
  assign bus.CO    = tc & eff_en;
  assign bus.WRAP  = wrap_q;
  assign bus.LDERR = lderr_q;

endmodule
